// File: rtl/ceespu_pkg.sv
// Shared encodings and defaults for the ceespu unified-memory arbiter.
package ceespu_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
  typedef enum logic {ST_NORMAL = 1'b0, ST_FORCE_I = 1'b1} arbState_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   killed;
  } retTag_t;
endpackage

// File: rtl/ceespu_mem_retpipe.sv
// Return-tag shift register: follows each read for READ_LATENCY cycles so the
// returning word can be steered to its requester; a flush kills fetch tags.
module ceespu_mem_retpipe import ceespu_pkg::*; #(
  parameter int READ_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  owner_e  tagOwner,
  input  logic    flush,
  output retTag_t tail
);
  retTag_t pipe [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LATENCY; k++) pipe[k] <= '0;
    end else begin
      // A fetch issued in the flush cycle belongs to the new path: never killed.
      pipe[0] <= '{valid: load, owner: tagOwner, killed: 1'b0};
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe[k] <= pipe[k-1];
        if (flush && pipe[k-1].owner == OWN_I) pipe[k].killed <= 1'b1;
      end
    end
  end

  assign tail = pipe[READ_LATENCY-1];
endmodule

// File: rtl/ceespu_mem_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one single-port synchronous RAM
// and routes read returns back to whichever side issued them.
module ceespu_mem_arbiter import ceespu_pkg::*; #(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_ireq,
  input  logic [ADDR_W-1:0]   I_iaddr,
  input  logic                I_iflush,
  output logic                O_igrant,
  output logic                O_ivalid,
  output logic [DATA_W-1:0]   O_irdata,
  input  logic                I_dreq,
  input  logic [ADDR_W-1:0]   I_daddr,
  input  logic [DATA_W/8-1:0] I_dwe,
  input  logic [DATA_W-1:0]   I_dwdata,
  output logic                O_dgrant,
  output logic                O_dvalid,
  output logic [DATA_W-1:0]   O_drdata,
  output logic                O_memE,
  output logic [ADDR_W-1:0]   O_memAddress,
  output logic [DATA_W/8-1:0] O_memWe,
  output logic [DATA_W-1:0]   O_memWData,
  input  logic [DATA_W-1:0]   I_memData
);
  arbState_e         state, stateNext;
  logic [3:0]        starve, starveNext;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  retTag_t           tail;

  // D normally wins (older instruction); FORCE_I hands one slot to a waiting fetch.
  always_comb begin
    O_igrant = 1'b0;
    O_dgrant = 1'b0;
    if (!I_rst) begin
      O_dgrant = I_dreq && !(state == ST_FORCE_I && I_ireq);
      O_igrant = I_ireq && !O_dgrant;
    end
  end

  always_comb begin
    starveNext = starve;
    stateNext  = state;
    if (O_igrant || !I_ireq)               starveNext = '0;
    else if (O_dgrant && starve != 4'hF)   starveNext = starve + 4'd1;
    if (state == ST_NORMAL) begin
      if (STARVE_LIMIT != 0 && starveNext == 4'(STARVE_LIMIT)) stateNext = ST_FORCE_I;
    end else if (O_igrant || !I_ireq) begin
      stateNext = ST_NORMAL;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state  <= ST_NORMAL;
      starve <= '0;
      addrQ  <= '0;
      wdataQ <= '0;
    end else begin
      state  <= stateNext;
      starve <= starveNext;
      addrQ  <= O_memAddress;
      wdataQ <= O_memWData;
    end
  end

  // Idle cycles keep address/wdata stable to avoid needless RAM pin toggling.
  always_comb begin
    O_memE       = O_igrant || O_dgrant;
    O_memWe      = '0;
    O_memAddress = addrQ;
    O_memWData   = wdataQ;
    if (O_dgrant) begin
      O_memAddress = I_daddr;
      O_memWe      = I_dwe;
      O_memWData   = I_dwdata;
    end else if (O_igrant) begin
      O_memAddress = I_iaddr;
    end
  end

  ceespu_mem_retpipe #(.READ_LATENCY(READ_LATENCY)) uRetPipe (
    .clk      (I_clk),
    .rst      (I_rst),
    .load     (O_igrant || (O_dgrant && I_dwe == '0)),
    .tagOwner (O_dgrant ? OWN_D : OWN_I),
    .flush    (I_iflush),
    .tail     (tail)
  );

  assign O_ivalid = !I_rst && tail.valid && tail.owner == OWN_I && !tail.killed && !I_iflush;
  assign O_dvalid = !I_rst && tail.valid && tail.owner == OWN_D;
  assign O_irdata = O_ivalid ? I_memData : '0;
  assign O_drdata = O_dvalid ? I_memData : '0;
endmodule

// File: tb/tb_ceespu_mem_arbiter.sv
// Directed bench: a per-cycle vector table on a READ_LATENCY=1 arbiter, plus
// hand sequences for flush (latency 3) and mid-flight reset (latency 2).
module tb_ceespu_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0, ireq = 1'b0, iflush = 1'b0, dreq = 1'b0;
  logic [15:0] iaddr = '0, daddr = '0;
  logic [3:0]  dwe = '0;
  logic [31:0] dwdata = '0;

  logic        igr [1:3], dgr [1:3], ivl [1:3], dvl [1:3], mE [1:3];
  logic [31:0] ird [1:3], drd [1:3], mWd [1:3], md [1:3];
  logic [15:0] mAddr [1:3];
  logic [3:0]  mWe [1:3];
  logic [31:0] mem [0:255];

  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  for (genvar L = 1; L <= 3; L++) begin : g
    ceespu_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LATENCY(L), .STARVE_LIMIT(4)) dut (
      .I_clk(clk), .I_rst(rst), .I_ireq(ireq), .I_iaddr(iaddr), .I_iflush(iflush),
      .O_igrant(igr[L]), .O_ivalid(ivl[L]), .O_irdata(ird[L]),
      .I_dreq(dreq), .I_daddr(daddr), .I_dwe(dwe), .I_dwdata(dwdata),
      .O_dgrant(dgr[L]), .O_dvalid(dvl[L]), .O_drdata(drd[L]),
      .O_memE(mE[L]), .O_memAddress(mAddr[L]), .O_memWe(mWe[L]), .O_memWData(mWd[L]),
      .I_memData(md[L]));
    logic [31:0] rp [1:L];
    always @(posedge clk) begin
      rp[1] <= mem[mAddr[L][9:2]];
      for (int k = 2; k <= L; k++) rp[k] <= rp[k-1];
    end
    assign md[L] = rp[L];
  end

  // RAM model written by the latency-1 instance; reset reloads the preset words.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h01] <= 32'hDEADBEEF;
      mem[8'h04] <= 32'h11110010;
      mem[8'h40] <= 32'h22220100;
    end else if (mE[1]) begin
      for (int b = 0; b < 4; b++)
        if (mWe[1][b]) mem[mAddr[1][9:2]][8*b +: 8] <= mWd[1][8*b +: 8];
    end
  end

  typedef struct {
    logic rst, ireq; logic [15:0] iaddr; logic iflush, dreq; logic [15:0] daddr;
    logic [3:0] dwe; logic [31:0] dwdata;
    logic eIg, eDg, eIv; logic [31:0] eIr; logic eDv; logic [31:0] eDr;
    logic eE; logic [3:0] eWe; logic [15:0] eA;
  } vec_t;
  vec_t vq [$];

  task automatic add(input logic r, input logic iq, input logic [15:0] ia, input logic fl,
                     input logic dq, input logic [15:0] da, input logic [3:0] we, input logic [31:0] wd,
                     input logic eIg, input logic eDg, input logic eIv, input logic [31:0] eIr,
                     input logic eDv, input logic [31:0] eDr, input logic eE, input logic [3:0] eWe,
                     input logic [15:0] eA);
    vec_t v;
    v.rst = r; v.ireq = iq; v.iaddr = ia; v.iflush = fl; v.dreq = dq; v.daddr = da;
    v.dwe = we; v.dwdata = wd; v.eIg = eIg; v.eDg = eDg; v.eIv = eIv; v.eIr = eIr;
    v.eDv = eDv; v.eDr = eDr; v.eE = eE; v.eWe = eWe; v.eA = eA;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iq, input logic [15:0] ia, input logic fl,
                       input logic dq, input logic [15:0] da, input logic [3:0] we, input logic [31:0] wd);
    @(negedge clk);
    rst = r; ireq = iq; iaddr = ia; iflush = fl; dreq = dq; daddr = da; dwe = we; dwdata = wd;
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 0, 0, 16'h0, 4'h0, 32'h0);
  endtask

  initial begin
    // rst ireq iaddr fl dreq daddr dwe dwdata | igr dgr ivl irdata dvl drdata memE memWe addr
    add(1, 1, 16'h0004, 0, 1, 16'h0100, 4'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 4'h0, 16'h0);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 4'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 4'h0, 16'h0);
    add(0, 1, 16'h0004, 0, 0, 16'h0000, 4'h0, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0, 1, 4'h0, 16'h0004);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 4'h0, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0, 0, 4'h0, 16'h0004);
    add(0, 1, 16'h0010, 0, 1, 16'h0100, 4'h0, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 4'h0, 16'h0100);
    add(0, 1, 16'h0010, 0, 0, 16'h0000, 4'h0, 32'h0, 1, 0, 0, 32'h0, 1, 32'h22220100, 1, 4'h0, 16'h0010);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 4'h0, 32'h0, 0, 0, 1, 32'h11110010, 0, 32'h0, 0, 4'h0, 16'h0010);
    add(0, 0, 16'h0000, 0, 1, 16'h0200, 4'h3, 32'h12345678, 0, 1, 0, 32'h0, 0, 32'h0, 1, 4'h3, 16'h0200);
    add(0, 0, 16'h0000, 0, 1, 16'h0200, 4'h0, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 4'h0, 16'h0200);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 4'h0, 32'h0, 0, 0, 0, 32'h0, 1, 32'h00005678, 0, 4'h0, 16'h0200);
    // starvation: both requesting for 10 cycles
    add(0, 1, 16'h0004, 0, 1, 16'h0100, 4'h0, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 4'h0, 16'h0100);
    for (int i = 0; i < 3; i++)
      add(0, 1, 16'h0004, 0, 1, 16'h0100, 4'h0, 32'h0, 0, 1, 0, 32'h0, 1, 32'h22220100, 1, 4'h0, 16'h0100);
    add(0, 1, 16'h0004, 0, 1, 16'h0100, 4'h0, 32'h0, 1, 0, 0, 32'h0, 1, 32'h22220100, 1, 4'h0, 16'h0004);
    add(0, 1, 16'h0004, 0, 1, 16'h0100, 4'h0, 32'h0, 0, 1, 1, 32'hDEADBEEF, 0, 32'h0, 1, 4'h0, 16'h0100);
    for (int i = 0; i < 3; i++)
      add(0, 1, 16'h0004, 0, 1, 16'h0100, 4'h0, 32'h0, 0, 1, 0, 32'h0, 1, 32'h22220100, 1, 4'h0, 16'h0100);
    add(0, 1, 16'h0004, 0, 1, 16'h0100, 4'h0, 32'h0, 1, 0, 0, 32'h0, 1, 32'h22220100, 1, 4'h0, 16'h0004);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 4'h0, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0, 0, 4'h0, 16'h0004);
    // flush at latency 1: returning fetch suppressed, fetch granted with the flush survives
    add(0, 1, 16'h0004, 0, 0, 16'h0000, 4'h0, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0, 1, 4'h0, 16'h0004);
    add(0, 1, 16'h0010, 1, 0, 16'h0000, 4'h0, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0, 1, 4'h0, 16'h0010);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 4'h0, 32'h0, 0, 0, 1, 32'h11110010, 0, 32'h0, 0, 4'h0, 16'h0010);

    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      drive(v.rst, v.ireq, v.iaddr, v.iflush, v.dreq, v.daddr, v.dwe, v.dwdata);
      chk($sformatf("row%0d igrant", i), 32'(igr[1]), 32'(v.eIg));
      chk($sformatf("row%0d dgrant", i), 32'(dgr[1]), 32'(v.eDg));
      chk($sformatf("row%0d ivalid", i), 32'(ivl[1]), 32'(v.eIv));
      chk($sformatf("row%0d dvalid", i), 32'(dvl[1]), 32'(v.eDv));
      chk($sformatf("row%0d memE", i), 32'(mE[1]), 32'(v.eE));
      chk($sformatf("row%0d memWe", i), 32'(mWe[1]), 32'(v.eWe));
      if (v.eIv) chk($sformatf("row%0d irdata", i), ird[1], v.eIr);
      if (v.eDv) chk($sformatf("row%0d drdata", i), drd[1], v.eDr);
      if (!v.rst) chk($sformatf("row%0d memAddress", i), 32'(mAddr[1]), 32'(v.eA));
      if (v.eDg && v.eWe != 4'h0) chk($sformatf("row%0d memWData", i), mWd[1], v.dwdata);
    end

    // Flush with READ_LATENCY=3: two older fetches die, the flush-cycle fetch returns.
    drive(1, 0, 16'h0, 0, 0, 16'h0, 4'h0, 32'h0);
    drive(0, 1, 16'h0004, 0, 0, 16'h0, 4'h0, 32'h0);
    chk("fl3 c0 igrant", 32'(igr[3]), 32'd1);
    drive(0, 1, 16'h0010, 0, 0, 16'h0, 4'h0, 32'h0);
    chk("fl3 c1 igrant", 32'(igr[3]), 32'd1);
    drive(0, 1, 16'h0100, 1, 0, 16'h0, 4'h0, 32'h0);
    chk("fl3 c2 igrant", 32'(igr[3]), 32'd1);
    chk("fl3 c2 ivalid", 32'(ivl[3]), 32'd0);
    idle();
    chk("fl3 c3 ivalid", 32'(ivl[3]), 32'd0);
    idle();
    chk("fl3 c4 ivalid", 32'(ivl[3]), 32'd0);
    idle();
    chk("fl3 c5 ivalid", 32'(ivl[3]), 32'd1);
    chk("fl3 c5 irdata", ird[3], 32'h22220100);

    // Reset mid-flight with READ_LATENCY=2: the read never returns.
    drive(1, 0, 16'h0, 0, 0, 16'h0, 4'h0, 32'h0);
    drive(0, 0, 16'h0, 0, 1, 16'h0100, 4'h0, 32'h0);
    chk("rst2 c0 dgrant", 32'(dgr[2]), 32'd1);
    drive(1, 1, 16'h0004, 1, 1, 16'h0100, 4'hF, 32'hFFFFFFFF);
    chk("rst2 c1 igrant", 32'(igr[2]), 32'd0);
    chk("rst2 c1 dgrant", 32'(dgr[2]), 32'd0);
    chk("rst2 c1 ivalid", 32'(ivl[2]), 32'd0);
    chk("rst2 c1 dvalid", 32'(dvl[2]), 32'd0);
    chk("rst2 c1 memE", 32'(mE[2]), 32'd0);
    chk("rst2 c1 memWe", 32'(mWe[2]), 32'd0);
    idle();
    chk("rst2 c2 dvalid", 32'(dvl[2]), 32'd0);
    idle();
    chk("rst2 c3 dvalid", 32'(dvl[2]), 32'd0);
    chk("rst2 c3 ivalid", 32'(ivl[2]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ceespu_mem_arbiter.md
Name: ceespu_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the fetch stage (I port) and the load/store path (D port), so the core can run from one unified RAM.
- Decides each cycle which requester drives the memory and drives the memory command.
- Tracks in-flight reads and routes returning read data to the requester that issued them.
- Sits between the ceespu core memory interfaces and the RAM; replaces the separate imem/dmem buses.

Parameters:
- ADDR_W, 16, byte address width on all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- READ_LATENCY, 1, cycles from memory command to I_memData valid; legal range 1..4.
- STARVE_LIMIT, 4, consecutive D grants allowed while a fetch waits; legal range 1..15; 0 disables the anti-starvation rule.

Ports:
- I_clk  in  1  clock
- I_rst  in  1  synchronous reset, active-high
- I_ireq  in  1  fetch request; held with I_iaddr until O_igrant
- I_iaddr  in  ADDR_W  fetch byte address
- I_iflush  in  1  branch redirect; discards in-flight fetch returns
- O_igrant  out  1  fetch accepted this cycle
- O_ivalid  out  1  O_irdata valid
- O_irdata  out  DATA_W  fetch read data
- I_dreq  in  1  data request; held with address, write data and write enables until O_dgrant
- I_daddr  in  ADDR_W  data byte address
- I_dwe  in  DATA_W/8  byte write enables; 0 means read
- I_dwdata  in  DATA_W  store data
- O_dgrant  out  1  data request accepted this cycle
- O_dvalid  out  1  O_drdata valid (reads only)
- O_drdata  out  DATA_W  load read data
- O_memE  out  1  memory enable
- O_memAddress  out  ADDR_W  memory address
- O_memWe  out  DATA_W/8  memory byte write enables
- O_memWData  out  DATA_W  memory write data
- I_memData  in  DATA_W  memory read data, READ_LATENCY cycles after the command

Behaviour:
- Arbitration is combinational from the requests and the registered state. The memory command is driven in the same cycle as the grant. At most one grant per cycle.
- Default priority: D wins over I, because the data access belongs to the older instruction.
- Starvation counter `starve` (4 bit):
  - Increments on a cycle where D is granted while I_ireq=1.
  - Clears on an I grant, or when I_ireq=0.
  - When starve==STARVE_LIMIT (with STARVE_LIMIT≠0), state FORCE_I is entered. In FORCE_I, I wins over D on the next cycle I_ireq=1; FORCE_I then returns to NORMAL.
- FSM states:
  - NORMAL -> FORCE_I when the limit is reached.
  - FORCE_I -> NORMAL on an I grant, or when I_ireq drops.
- Memory command when nothing is granted: O_memE=0, O_memWe=0, and address/wdata hold their last driven values.
- I grant drives: O_memAddress=I_iaddr, O_memWe=0.
- D grant drives: O_memAddress=I_daddr, O_memWe=I_dwe, O_memWData=I_dwdata.
- Return pipeline: a READ_LATENCY-deep shift register of {valid, owner, killed}, loaded on every read grant. D writes load nothing.
  - At the tail, an owner=D entry pulses O_dvalid for 1 cycle with O_drdata=I_memData.
  - An owner=I entry that is not killed pulses O_ivalid for 1 cycle with O_irdata=I_memData.
- I_iflush sets `killed` on every owner=I entry in flight, including one returning that same cycle (O_ivalid is suppressed). A fetch granted in the flush cycle itself is not killed.
- Read data outputs are combinational pass-through of I_memData gated by the valid outputs. Data outputs are unspecified while their valid is low.
- Back-to-back grants are legal every cycle. Full throughput is one access per cycle.
- Reset, synchronous:
  - Pipeline cleared; starve=0; state NORMAL.
  - While I_rst=1: O_igrant=O_dgrant=O_ivalid=O_dvalid=O_memE=0 and O_memWe=0.
  - Reset mid-transfer drops every in-flight return. No valid pulses after reset deasserts for commands issued before it.
- Simultaneous I_iflush and I_rst: reset dominates.

Decomposition:
- Shared package ceespu_pkg holds:
  - the owner encoding (OWN_I=0, OWN_D=1)
  - the arbiter state encoding (ST_NORMAL, ST_FORCE_I)
  - the default ADDR_W and DATA_W constants
- One natural sub-module: ceespu_mem_retpipe, the parameterised READ_LATENCY-deep return-tag shift register with its flush-kill input.

Test Plan:
- Fetch only, READ_LATENCY=1: I_ireq=1 with I_iaddr=0x0004 and mem[0x0004]=0xDEADBEEF -> O_igrant=1 in cycle 0, O_memE=1, O_ivalid=1 with O_irdata=0xDEADBEEF in cycle 1.
- Same-cycle conflict: I_ireq=1 @0x0010 and I_dreq=1 read @0x0100 -> D granted in cycle 0, I granted in cycle 1; O_dvalid in cycle 1 and O_ivalid in cycle 2, each with the correct word.
- Starvation, STARVE_LIMIT=4: I_dreq held high for 10 cycles with I_ireq=1 -> D granted in cycles 0-3, I granted in cycle 4, D resumes in cycle 5.
- Store: I_dreq with I_dwe=4'b0011, I_daddr=0x0200, I_dwdata=0x12345678 -> O_memWe=4'b0011, no O_dvalid. A following read of 0x0200 returns the low halfword 0x5678.
- Flush, READ_LATENCY=3: fetches granted in cycles 0 and 1, I_iflush in cycle 2 together with a new fetch grant -> no O_ivalid in cycles 3-4, O_ivalid in cycle 5 for the new fetch.
- Reset mid-flight: read granted in cycle 0 with READ_LATENCY=2, I_rst=1 in cycle 1 -> no O_dvalid in cycle 2; all outputs 0 during reset.
